// File: rtl/pcie_rq_arbiter.sv
// Packet-granular N:1 arbiter feeding the PCIe Requester Request AXIS port.
// The winning port owns the link until its tlast beat; outputs come from a 2-entry skid buffer.
module pcie_rq_arbiter #(
  parameter int NUM_PORTS           = 4,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int ARB_MODE            = 0
) (
  input  logic                                     user_clk,
  input  logic                                     user_reset,
  input  logic                                     user_lnk_up,
  input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [NUM_PORTS*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [NUM_PORTS-1:0]                     req_tlast,
  input  logic [NUM_PORTS-1:0]                     req_tvalid,
  output logic [NUM_PORTS-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]                  s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]           s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]                    s_axis_rq_tkeep,
  output logic                                     s_axis_rq_tlast,
  output logic                                     s_axis_rq_tvalid,
  input  logic [3:0]                               s_axis_rq_tready,
  output logic [$clog2(NUM_PORTS)-1:0]             grant_id,
  output logic                                     arb_busy
);
  localparam int ID_W   = $clog2(NUM_PORTS);
  localparam int WORD_W = C_DATA_WIDTH + AXI4_RQ_TUSER_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic {IDLE, PKT} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   grant_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [WORD_W-1:0] out_word_reg;
  logic [WORD_W-1:0] skid_word_reg;
  logic              out_valid_reg;
  logic              skid_valid_reg;

  logic [WORD_W-1:0] port_word [NUM_PORTS];
  logic [ID_W-1:0]   winner;
  logic              winner_found;
  int                cand;
  logic              skid_full;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] push_word;
  logic              unused_tready;

  // Each port's beat packed as one word so tdata/tuser/tkeep/tlast travel together.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_word[gi] = {req_tlast[gi],
                            req_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH],
                            req_tuser[gi*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH],
                            req_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH]};
    assign req_tready[gi] = (state_reg == PKT) && (grant_reg == ID_W'(gi)) && !skid_full;
  end

  // Search starts at rr_ptr for round-robin, at port 0 for fixed priority.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = ((ARB_MODE == 0) ? int'(rr_ptr_reg) : 0) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!winner_found && req_tvalid[ID_W'(cand)]) begin
        winner_found = 1'b1;
        winner       = ID_W'(cand);
      end
    end
  end

  assign skid_full = out_valid_reg && skid_valid_reg;
  assign push_word = port_word[grant_reg];
  assign push      = (state_reg == PKT) && req_tvalid[grant_reg] && !skid_full;
  assign pop       = out_valid_reg && s_axis_rq_tready[0];
  assign unused_tready = ^s_axis_rq_tready[3:1];

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= '0;
      out_word_reg   <= '0;
      skid_word_reg  <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (user_lnk_up && winner_found) begin
            grant_reg <= winner;
            state_reg <= PKT;
          end
        end
        PKT: begin
          if (push && push_word[WORD_W-1]) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= (grant_reg == ID_W'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // The skid entry is only ever occupied behind a valid output entry.
      if (skid_valid_reg) begin
        if (pop) begin
          out_word_reg   <= skid_word_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (!out_valid_reg || pop) begin
        out_valid_reg <= push;
        if (push) out_word_reg <= push_word;
      end else if (push) begin
        skid_valid_reg <= 1'b1;
        skid_word_reg  <= push_word;
      end
    end
  end

  assign s_axis_rq_tdata  = out_word_reg[C_DATA_WIDTH-1:0];
  assign s_axis_rq_tuser  = out_word_reg[C_DATA_WIDTH +: AXI4_RQ_TUSER_WIDTH];
  assign s_axis_rq_tkeep  = out_word_reg[C_DATA_WIDTH+AXI4_RQ_TUSER_WIDTH +: KEEP_WIDTH];
  assign s_axis_rq_tlast  = out_word_reg[WORD_W-1];
  assign s_axis_rq_tvalid = out_valid_reg;
  assign grant_id         = grant_reg;
  assign arb_busy         = (state_reg == PKT) || out_valid_reg;
endmodule
